// File: rtl/cl_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master between NUM_REQ requesters.
// ARID carries the requester index on top; R beats are routed back by that tag.
module cl_axi_rd_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ID_W      = 6,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned MAX_OUTST = 8,
  localparam int unsigned IDX_W    = $clog2(NUM_REQ),
  localparam int unsigned MID_W    = ID_W + IDX_W
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_REQ-1:0]          s_arvalid,
  output logic [NUM_REQ-1:0]          s_arready,
  input  logic [NUM_REQ*ADDR_W-1:0]   s_araddr,
  input  logic [NUM_REQ*8-1:0]        s_arlen,
  input  logic [NUM_REQ*3-1:0]        s_arsize,
  input  logic [NUM_REQ*ID_W-1:0]     s_arid,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  output logic [ADDR_W-1:0]           m_araddr,
  output logic [7:0]                  m_arlen,
  output logic [2:0]                  m_arsize,
  output logic [MID_W-1:0]            m_arid,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  input  logic [MID_W-1:0]            m_rid,
  input  logic [DATA_W-1:0]           m_rdata,
  input  logic [1:0]                  m_rresp,
  input  logic                        m_rlast,
  output logic [NUM_REQ-1:0]          s_rvalid,
  input  logic [NUM_REQ-1:0]          s_rready,
  output logic [ID_W-1:0]             s_rid,
  output logic [DATA_W-1:0]           s_rdata,
  output logic [1:0]                  s_rresp,
  output logic                        s_rlast,
  output logic                        err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   outst [NUM_REQ];

  logic [NUM_REQ-1:0] eligible;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand;
  logic [ADDR_W-1:0]  sel_addr;
  logic [7:0]         sel_len;
  logic [2:0]         sel_size;
  logic [ID_W-1:0]    sel_id;

  logic [IDX_W-1:0]   r_idx;
  logic               r_last_hs;
  logic               underflow;
  logic [NUM_REQ-1:0] cnt_inc;
  logic [NUM_REQ-1:0] cnt_dec;

  // Pick the first eligible requester at or after rr_ptr; descending scan so the lowest offset wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      eligible[i] = s_arvalid[i] && (outst[i] < CNT_W'(MAX_OUTST));
    end
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      cand = rr_ptr + IDX_W'(k);
      if (aresetn && (state == IDLE) && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_id    = '0;
    s_arready = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_addr     = s_araddr[i*ADDR_W +: ADDR_W];
        sel_len      = s_arlen[i*8 +: 8];
        sel_size     = s_arsize[i*3 +: 3];
        sel_id       = s_arid[i*ID_W +: ID_W];
        s_arready[i] = grant_valid;
      end
    end
  end

  // R channel is a pure combinational demux keyed by the index bits of RID.
  always_comb begin
    r_idx    = m_rid[MID_W-1:ID_W];
    s_rvalid = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (r_idx == IDX_W'(i)) s_rvalid[i] = m_rvalid;
    end
    m_rready  = s_rready[r_idx];
    s_rid     = m_rid[ID_W-1:0];
    s_rdata   = m_rdata;
    s_rresp   = m_rresp;
    s_rlast   = m_rlast;
    r_last_hs = m_rvalid && m_rready && m_rlast;
    underflow = r_last_hs && (outst[r_idx] == '0);
  end

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cnt_inc[i] = grant_valid && (grant_idx == IDX_W'(i));
      cnt_dec[i] = r_last_hs && (r_idx == IDX_W'(i)) && (outst[i] != '0);
    end
  end

  // AR FSM: capture the winner's payload, then hold it on the master until accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arid    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state     <= ISSUE;
            rr_ptr    <= grant_idx + IDX_W'(1);
            m_arvalid <= 1'b1;
            m_araddr  <= sel_addr;
            m_arlen   <= sel_len;
            m_arsize  <= sel_size;
            m_arid    <= {grant_idx, sel_id};
          end
        end
        ISSUE: begin
          if (m_arready) begin
            state     <= IDLE;
            m_arvalid <= 1'b0;
          end
        end
      endcase
    end
  end

  // An underflowing rlast never decrements, so a same-cycle grant still counts.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(NUM_REQ); i++) outst[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (cnt_inc[i] && !cnt_dec[i]) begin
          outst[i] <= outst[i] + CNT_W'(1);
        end else if (!cnt_inc[i] && cnt_dec[i]) begin
          outst[i] <= outst[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_o <= 1'b0;
    end else if (underflow) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cl_axi_rd_arbiter.sv
// Directed bench for cl_axi_rd_arbiter with an AR scoreboard queue and R routing checks.
module tb_cl_axi_rd_arbiter;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned ID_W      = 6;
  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned DATA_W    = 512;
  localparam int unsigned MAX_OUTST = 2;
  localparam int unsigned MID_W     = 7;

  typedef struct packed {
    logic [MID_W-1:0]  id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
  } ar_t;

  logic                      aclk;
  logic                      aresetn;
  logic [NUM_REQ-1:0]        s_arvalid;
  logic [NUM_REQ-1:0]        s_arready;
  logic [NUM_REQ*ADDR_W-1:0] s_araddr;
  logic [NUM_REQ*8-1:0]      s_arlen;
  logic [NUM_REQ*3-1:0]      s_arsize;
  logic [NUM_REQ*ID_W-1:0]   s_arid;
  logic                      m_arvalid;
  logic                      m_arready;
  logic [ADDR_W-1:0]         m_araddr;
  logic [7:0]                m_arlen;
  logic [2:0]                m_arsize;
  logic [MID_W-1:0]          m_arid;
  logic                      m_rvalid;
  logic                      m_rready;
  logic [MID_W-1:0]          m_rid;
  logic [DATA_W-1:0]         m_rdata;
  logic [1:0]                m_rresp;
  logic                      m_rlast;
  logic [NUM_REQ-1:0]        s_rvalid;
  logic [NUM_REQ-1:0]        s_rready;
  logic [ID_W-1:0]           s_rid;
  logic [DATA_W-1:0]         s_rdata;
  logic [1:0]                s_rresp;
  logic                      s_rlast;
  logic                      err_o;

  int compared   = 0;
  int mismatched = 0;

  ar_t              ar_q[$];
  logic [ADDR_W-1:0] addr_t [NUM_REQ];
  logic [7:0]        len_t  [NUM_REQ];
  logic [2:0]        size_t [NUM_REQ];
  logic [ID_W-1:0]   id_t   [NUM_REQ];

  cl_axi_rd_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arid(s_arid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .err_o(err_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_req(input int i, input logic [63:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [5:0] id);
    addr_t[i] = a;
    len_t[i]  = l;
    size_t[i] = s;
    id_t[i]   = id;
    s_araddr[i*ADDR_W +: ADDR_W] = a;
    s_arlen[i*8 +: 8]            = l;
    s_arsize[i*3 +: 3]           = s;
    s_arid[i*ID_W +: ID_W]       = id;
  endtask

  task automatic push_exp(input int w);
    ar_t e;
    e.id   = {1'(w), id_t[w]};
    e.addr = addr_t[w];
    e.len  = len_t[w];
    e.size = size_t[w];
    ar_q.push_back(e);
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: score any AR handshake and R beat seen this cycle, then move to the next negedge.
  task automatic cyc();
    ar_t e;
    logic [NUM_REQ-1:0] exp_rv;
    #1;
    if (m_arvalid && m_arready) begin
      check("ar_queue_nonempty", 512'(ar_q.size() != 0), 512'(1));
      if (ar_q.size() != 0) begin
        e = ar_q.pop_front();
        check("m_arid", 512'(m_arid), 512'(e.id));
        check("m_araddr", 512'(m_araddr), 512'(e.addr));
        check("m_arlen", 512'(m_arlen), 512'(e.len));
        check("m_arsize", 512'(m_arsize), 512'(e.size));
      end
    end
    if (m_rvalid) begin
      exp_rv = m_rid[MID_W-1] ? 2'b10 : 2'b01;
      check("s_rvalid_route", 512'(s_rvalid), 512'(exp_rv));
      check("m_rready_route", 512'(m_rready), 512'(s_rready[m_rid[MID_W-1]]));
      check("s_rid", 512'(s_rid), 512'(m_rid[ID_W-1:0]));
      check("s_rdata", s_rdata, m_rdata);
      check("s_rlast", 512'(s_rlast), 512'(m_rlast));
    end else begin
      check("s_rvalid_quiet", 512'(s_rvalid), 512'(0));
    end
    @(negedge aclk);
  endtask

  task automatic r_last(input int i);
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    m_rid    = {1'(i), id_t[i]};
    s_rready = (i == 0) ? 2'b01 : 2'b10;
    cyc();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    s_rready = 2'b00;
  endtask

  initial begin
    aresetn   = 1'b0;
    s_arvalid = '0;
    s_araddr  = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arid    = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rid     = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rlast   = 1'b0;
    s_rready  = '0;
    load_req(0, 64'h1000, 8'd7, 3'd6, 6'h05);
    load_req(1, 64'h3000, 8'd1, 3'd5, 6'h22);
    s_arvalid = 2'b11;

    // Reset values, including s_arready held low while requests are pending
    @(negedge aclk);
    settle();
    check("rst_m_arvalid", 512'(m_arvalid), 512'(0));
    check("rst_m_araddr", 512'(m_araddr), 512'(0));
    check("rst_m_arid", 512'(m_arid), 512'(0));
    check("rst_m_arlen", 512'(m_arlen), 512'(0));
    check("rst_err", 512'(err_o), 512'(0));
    check("rst_s_arready", 512'(s_arready), 512'(0));
    s_arvalid = 2'b00;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    // Single request from requester 0, then an 8-beat burst back
    s_arvalid = 2'b01;
    settle();
    check("t1_grant", 512'(s_arready), 512'(2'b01));
    push_exp(0);
    cyc();
    s_arvalid = 2'b00;
    settle();
    check("t1_m_arvalid", 512'(m_arvalid), 512'(1));
    check("t1_m_arid", 512'(m_arid), 512'(7'h05));
    check("t1_no_grant", 512'(s_arready), 512'(0));
    m_arready = 1'b1;
    cyc();
    m_arready = 1'b0;
    settle();
    check("t1_m_arvalid_drop", 512'(m_arvalid), 512'(0));
    check("t1_outst0_one", 512'(dut.outst[0]), 512'(1));
    s_rready = 2'b01;
    for (int b = 0; b < 8; b++) begin
      m_rvalid = 1'b1;
      m_rid    = 7'h05;
      m_rdata  = {16{32'(b + 32'hA0)}};
      m_rresp  = 2'(b);
      m_rlast  = (b == 7);
      cyc();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    s_rready = 2'b00;
    settle();
    check("t1_outst0_zero", 512'(dut.outst[0]), 512'(0));

    // Round robin, both requesters continuously valid (rr_ptr now points at 1)
    load_req(0, 64'h2000, 8'd3, 3'd6, 6'h11);
    s_arvalid = 2'b11;
    m_arready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      settle();
      check("rr_grant", 512'(s_arready), 512'((g % 2 == 0) ? 2'b10 : 2'b01));
      push_exp((g % 2 == 0) ? 1 : 0);
      cyc();
      settle();
      check("rr_issue_gap", 512'(s_arready), 512'(0));
      check("rr_m_arvalid", 512'(m_arvalid), 512'(1));
      cyc();
    end

    // Both at the credit limit: blocked until an rlast returns a credit
    settle();
    check("credit_block", 512'(s_arready), 512'(0));
    cyc();
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = {1'b1, id_t[1]}; s_rready = 2'b10;
    settle();
    check("credit_same_cycle", 512'(s_arready), 512'(0));
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 2'b00;
    settle();
    check("credit_reenable1", 512'(s_arready), 512'(2'b10));
    push_exp(1);
    cyc();
    cyc();
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = {1'b0, id_t[0]}; s_rready = 2'b01;
    settle();
    check("credit_block0", 512'(s_arready), 512'(0));
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 2'b00;
    settle();
    check("credit_reenable0", 512'(s_arready), 512'(2'b01));
    push_exp(0);
    cyc();
    cyc();
    s_arvalid = 2'b00;
    m_arready = 1'b0;
    r_last(0);
    r_last(1);

    // Backpressure: payload held for 5 cycles, no new grants
    load_req(0, 64'h4000, 8'd15, 3'd6, 6'h2A);
    s_arvalid = 2'b01;
    settle();
    check("bp_grant", 512'(s_arready), 512'(2'b01));
    push_exp(0);
    cyc();
    s_arvalid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("bp_m_arvalid", 512'(m_arvalid), 512'(1));
      check("bp_m_araddr", 512'(m_araddr), 512'(64'h4000));
      check("bp_m_arid", 512'(m_arid), 512'(7'h2A));
      check("bp_no_grant", 512'(s_arready), 512'(0));
      cyc();
    end
    m_arready = 1'b1;
    cyc();
    m_arready = 1'b0;
    settle();
    check("bp_idle_grant", 512'(s_arready), 512'(2'b10));
    push_exp(1);
    cyc();
    m_arready = 1'b1;
    s_arvalid = 2'b00;
    cyc();
    m_arready = 1'b0;

    // Grant and rlast to requester 1 in the same cycle
    r_last(1);
    s_arvalid = 2'b10;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = {1'b1, id_t[1]}; s_rready = 2'b10;
    settle();
    check("simul_grant", 512'(s_arready), 512'(2'b10));
    push_exp(1);
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 2'b00;
    s_arvalid = 2'b00;
    settle();
    check("simul_outst1", 512'(dut.outst[1]), 512'(1));
    m_arready = 1'b1;
    cyc();
    m_arready = 1'b0;
    r_last(1);
    r_last(0);
    r_last(0);
    settle();
    check("drain_outst0", 512'(dut.outst[0]), 512'(0));
    check("drain_outst1", 512'(dut.outst[1]), 512'(0));
    check("drain_err", 512'(err_o), 512'(0));

    // Underflow: rlast with nothing outstanding
    r_last(0);
    settle();
    check("uflow_err", 512'(err_o), 512'(1));
    check("uflow_outst0", 512'(dut.outst[0]), 512'(0));
    cyc(); cyc(); cyc();
    settle();
    check("uflow_sticky", 512'(err_o), 512'(1));

    // Reset during ISSUE with an R burst in flight
    load_req(0, 64'h5000, 8'd3, 3'd6, 6'h01);
    s_arvalid = 2'b01;
    settle();
    check("rst_t_grant", 512'(s_arready), 512'(2'b01));
    push_exp(0);
    cyc();
    m_rvalid = 1'b1; m_rlast = 1'b0; m_rid = {1'b0, id_t[0]}; s_rready = 2'b01;
    settle();
    check("rst_t_issue", 512'(m_arvalid), 512'(1));
    #1;
    aresetn = 1'b0;
    #1;
    ar_q.delete();
    check("rst_t_m_arvalid", 512'(m_arvalid), 512'(0));
    check("rst_t_m_araddr", 512'(m_araddr), 512'(0));
    check("rst_t_m_arid", 512'(m_arid), 512'(0));
    check("rst_t_m_arlen", 512'(m_arlen), 512'(0));
    check("rst_t_err", 512'(err_o), 512'(0));
    check("rst_t_outst0", 512'(dut.outst[0]), 512'(0));
    check("rst_t_s_arready", 512'(s_arready), 512'(0));
    check("rst_t_s_rvalid", 512'(s_rvalid), 512'(2'b01));
    m_rvalid = 1'b0;
    s_rready = 2'b00;
    @(negedge aclk);
    aresetn = 1'b1;

    // rr_ptr restarts at 0 after reset
    s_arvalid = 2'b11;
    settle();
    check("post_rst_grant", 512'(s_arready), 512'(2'b01));
    push_exp(0);
    m_arready = 1'b1;
    cyc();
    s_arvalid = 2'b00;
    cyc();
    m_arready = 1'b0;
    settle();
    check("ar_queue_drained", 512'(ar_q.size()), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
